ysyx22041405_ex_sched: RTL and testbench
========================================

// Module: ysyx22041405_ex_sched
// PURPOSE
// - EX-stage scheduler for the ysyx22041405 pipeline, sitting between ID and the EXU/LSU boundary.
// - Owns the ID->EX valid/ready handshake and the EX occupancy register.
// - Generates the forwarding selects for the EXU operand muxes and stalls EX on load-use hazards.
// - Sequences the ebreak drain/halt and applies branch flush to the EX slot.
// PARAMETERS
// - RA_W   5  register-address width
// - CNT_W  32 width of the optional performance counters
// PORTS
// - clk           in   1     clock; all state updates on posedge
// - rst           in   1     reset; asynchronous, active-high
// - id_valid      in   1     ID presents an instruction
// - id_ready      out  1     EX slot can accept the ID instruction this cycle
// - id_rs1/id_rs2 in   RA_W  source register addresses
// - id_rs1_used   in   1     instruction reads rs1
// - id_rs2_used   in   1     instruction reads rs2
// - id_rd         in   RA_W  destination register address
// - id_we         in   1     instruction writes rd
// - id_is_load    in   1     instruction is a load
// - id_ebreak     in   1     instruction is ebreak
// - ex_valid      out  1     EX slot occupied
// - ex_out_valid  out  1     EX result offered to LSU this cycle
// - ls_ready      in   1     LSU accepts the EX result
// - ex_fwd1_sel   out  2     rs1 source: 00 regfile, 01 LS-stage result, 10 WB-stage result
// - ex_fwd2_sel   out  2     rs2 source, same encoding as ex_fwd1_sel
// - ls_valid/ls_rd/ls_we/ls_is_load  in  1/RA_W/1/1  LS-stage occupancy info
// - wb_valid/wb_rd/wb_we             in  1/RA_W/1    WB-stage occupancy info
// - flush         in   1     branch redirect; kills the EX slot
// - halt          out  1     ebreak has retired from EX; sticky
// BEHAVIOUR
// - Reset values: ex_valid=0, ex_fwd*_sel=00, halt=0, FSM=RUN, EX fields=0, counters=0.
// - EX register captures id_rs1/rs2/used/rd/we/is_load/ebreak on id_valid & id_ready.
// - Hit rule (per operand n): n_used & ex_rsn!=0 & ex_rsn==stage_rd & stage_valid & stage_we.
// - ex_fwdn_sel: 01 on an LS hit; else 10 on a WB hit; else 00. LS takes priority over WB.
// - ld_haz = a rs1 or rs2 LS hit where ls_is_load=1. Loaded data is not yet available.
// - ex_out_valid = ex_valid & ~ld_haz.
// - ex_go = ex_out_valid & ls_ready.
// - id_ready = (state==RUN) & ~flush & (~ex_valid | ex_go).
// - Cycle update when not flushing:
//   - ex_valid <= capture ? 1 : (ex_go ? 0 : ex_valid).
//   - No new capture means a bubble enters EX.
// - flush: ex_valid<=0 next cycle and no capture that cycle. flush beats id_valid.
// - FSM: RUN -> DRAIN when an ebreak is captured.
// - FSM: DRAIN -> HALT when that ebreak leaves via ex_go; halt<=1 on the same edge.
// - FSM: DRAIN -> RUN on flush (ebreak killed).
// - FSM: HALT is absorbing until rst; id_ready=0 throughout DRAIN and HALT.
// - Simultaneous ebreak ex_go and flush in DRAIN: ex_go wins, go to HALT (ebreak has already left EX).
// - rst mid-operation: all state cleared asynchronously; any in-flight instruction is lost.
// - Throughput: 1 instruction/cycle with no hazards.
// - A load followed immediately by a dependent instruction costs exactly 1 bubble cycle.
// CONFIGURATION
// - EX_PERF_CNT_EN defined:
//   - Adds outputs perf_ex_retired[CNT_W] (increments on each ex_go).
//   - Adds perf_ld_stall[CNT_W] (increments each cycle ex_valid & ld_haz).
//   - Both counters wrap modulo 2^CNT_W and reset to 0.
// - EX_PERF_CNT_EN undefined: those ports and registers are absent; all other behaviour is identical.
// TESTING
// - Reset: rst=1 mid-run -> ex_valid=0, halt=0, fwd sels=00 immediately. Ports independent of clk.
// - Streaming: 4 independent ops, ls_ready=1 -> id_ready=1 each cycle, 4 ex_go pulses back-to-back.
// - Forwarding: EX rs1=5 with ls_rd=5 and wb_rd=5 valid -> ex_fwd1_sel=01. Same case with ls_rd=6 -> 10.
// - Forwarding: rs1=0 with ls_rd=0 -> 00.
// - Load-use: ls load rd=3, EX rs2=3 -> ex_out_valid=0, id_ready=0 for 1 cycle. Next cycle ex_fwd2_sel=10.
// - Backpressure/flush: ls_ready=0 for 3 cycles -> EX held, id_ready=0.
// - Backpressure/flush: flush & id_valid together -> ex_valid=0 next cycle, nothing captured.
// - Ebreak: capture ebreak -> id_ready=0; ex_go -> halt=1 next edge, stays 1 for 10 cycles.
// - Ebreak: flush while in DRAIN -> back to RUN.
// - Ebreak (EX_PERF_CNT_EN): 3 retires + 1 load stall -> perf_ex_retired=3, perf_ld_stall=1.

Source files
------------

// File: rtl/ysyx22041405_ex_sched.sv
// -----------------------------------------------------------------------------
// ysyx22041405_ex_sched
//
// EX-stage scheduler for the ysyx22041405 pipeline. It sits between ID and the
// EXU/LSU boundary and owns the control side of the EX slot:
//   * ID->EX valid/ready handshake and the EX occupancy register
//   * forwarding selects for the two EXU operand muxes
//   * load-use stall (loaded data is not available while the load is in LS)
//   * ebreak drain/halt sequencing and branch-flush of the EX slot
//
// Optional feature macro: EX_PERF_CNT_EN
//   When defined, adds the CNT_W parameter and two wrapping counters:
//     perf_ex_retired - instructions that left EX (ex_go)
//     perf_ld_stall   - cycles EX sat on a load-use hazard
//   When undefined, those counters and ports do not exist.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   id_valid / id_ready      ID->EX handshake
//   id_rs1, id_rs2           source register addresses of the ID instruction
//   id_rs1_used, id_rs2_used instruction reads rs1 / rs2
//   id_rd, id_we             destination register and its write enable
//   id_is_load, id_ebreak    instruction class flags
//   ex_valid                 EX slot occupied
//   ex_out_valid / ls_ready  EX->LS handshake
//   ex_fwd1_sel, ex_fwd2_sel operand source: 00 regfile, 01 LS, 10 WB
//   ls_valid/ls_rd/ls_we/ls_is_load  LS-stage occupancy
//   wb_valid/wb_rd/wb_we             WB-stage occupancy
//   flush                    branch redirect, kills the EX slot
//   halt                     sticky: ebreak has retired from EX
// -----------------------------------------------------------------------------
module ysyx22041405_ex_sched #(
  parameter int RA_W  = 5
`ifdef EX_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  // ID -> EX
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            id_ebreak,
  // EX slot / EX -> LS
  output logic            ex_valid,
  output logic            ex_out_valid,
  input  logic            ls_ready,
  output logic [1:0]      ex_fwd1_sel,
  output logic [1:0]      ex_fwd2_sel,
  // downstream occupancy
  input  logic            ls_valid,
  input  logic [RA_W-1:0] ls_rd,
  input  logic            ls_we,
  input  logic            ls_is_load,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_we,
  // control
  input  logic            flush,
  output logic            halt
`ifdef EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_ex_retired,
  output logic [CNT_W-1:0] perf_ld_stall
`endif
);

  // Forwarding select encoding shared by both operands.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_LS = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,  // normal issue
    S_DRAIN = 2'b01,  // ebreak sits in EX, no new issue
    S_HALT  = 2'b10   // ebreak retired, absorbing until reset
  } state_t;

  // Everything the EX slot remembers about its instruction.
  typedef struct packed {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            is_load;
    logic            ebreak;
  } ex_slot_t;

  state_t   state_q, state_d;
  ex_slot_t ex_q, ex_d;
  logic     ex_valid_q, ex_valid_d;

  logic     rs1_ls_hit, rs1_wb_hit;
  logic     rs2_ls_hit, rs2_wb_hit;
  logic     ld_haz;
  logic     ex_go;
  logic     capture;

  // ---------------------------------------------------------------------------
  // Hazard detection. x0 never matches: it is hard-wired zero, so a producer
  // "writing" it must not steer a consumer away from the regfile.
  // ---------------------------------------------------------------------------
  assign rs1_ls_hit = ex_q.rs1_used & (ex_q.rs1 != '0) & (ex_q.rs1 == ls_rd)
                    & ls_valid & ls_we;
  assign rs1_wb_hit = ex_q.rs1_used & (ex_q.rs1 != '0) & (ex_q.rs1 == wb_rd)
                    & wb_valid & wb_we;
  assign rs2_ls_hit = ex_q.rs2_used & (ex_q.rs2 != '0) & (ex_q.rs2 == ls_rd)
                    & ls_valid & ls_we;
  assign rs2_wb_hit = ex_q.rs2_used & (ex_q.rs2 != '0) & (ex_q.rs2 == wb_rd)
                    & wb_valid & wb_we;

  // A load in LS has not produced its data yet, so an LS hit on a load cannot
  // be forwarded; EX must wait one cycle until the load reaches WB.
  assign ld_haz = (rs1_ls_hit | rs2_ls_hit) & ls_is_load;

  // LS holds the younger write to the same register, so it wins over WB.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned (which would infer a latch).
    ex_fwd1_sel = FWD_RF;
    ex_fwd2_sel = FWD_RF;
    if (rs1_ls_hit)      ex_fwd1_sel = FWD_LS;
    else if (rs1_wb_hit) ex_fwd1_sel = FWD_WB;
    if (rs2_ls_hit)      ex_fwd2_sel = FWD_LS;
    else if (rs2_wb_hit) ex_fwd2_sel = FWD_WB;
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign ex_out_valid = ex_valid_q & ~ld_haz;
  assign ex_go        = ex_out_valid & ls_ready;
  assign capture      = id_valid & id_ready;
  assign ex_valid     = ex_valid_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of block order.
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (capture && id_ebreak) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The ebreak leaving via ex_go has already escaped the flush, so
        // retirement takes priority over a coincident redirect.
        if (ex_go && ex_q.ebreak) state_d = S_HALT;
        else if (flush)           state_d = S_RUN;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    id_ready = 1'b0;
    halt     = 1'b0;
    unique case (state_q)
      S_RUN:   id_ready = ~flush & (~ex_valid_q | ex_go);
      S_DRAIN: id_ready = 1'b0;
      S_HALT:  halt     = 1'b1;
      default: id_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EX slot
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (capture) begin
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rs1_used = id_rs1_used;
      ex_d.rs2_used = id_rs2_used;
      ex_d.rd       = id_rd;
      ex_d.we       = id_we;
      ex_d.is_load  = id_is_load;
      ex_d.ebreak   = id_ebreak;
    end
    // flush already blocks capture through id_ready; it also empties the slot.
    if (flush)        ex_valid_d = 1'b0;
    else if (capture) ex_valid_d = 1'b1;
    else if (ex_go)   ex_valid_d = 1'b0;
  end

  // NOTE: the slot fields are reset as well as the valid bit: the forwarding
  // selects are decoded from them directly, and must read 00 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef EX_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, wrapping modulo 2^CNT_W.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] perf_ex_retired_q;
  logic [CNT_W-1:0] perf_ld_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ex_retired_q <= '0;
      perf_ld_stall_q   <= '0;
    end else begin
      perf_ex_retired_q <= perf_ex_retired_q + CNT_W'(ex_go);
      perf_ld_stall_q   <= perf_ld_stall_q + CNT_W'(ex_valid_q & ld_haz);
    end
  end

  assign perf_ex_retired = perf_ex_retired_q;
  assign perf_ld_stall   = perf_ld_stall_q;
`endif

endmodule

// File: tb/tb_ysyx22041405_ex_sched.sv
// -----------------------------------------------------------------------------
// Testbench for ysyx22041405_ex_sched.
// Directed sequence in one initial block; every instruction expected to leave
// EX has its expected forwarding selects pushed to a scoreboard queue, and a
// negedge monitor pops and compares them on each ex_go.
// -----------------------------------------------------------------------------
module tb_ysyx22041405_ex_sched;

  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic            id_ready;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used, id_we, id_is_load, id_ebreak;
  logic            ex_valid, ex_out_valid, ls_ready;
  logic [1:0]      ex_fwd1_sel, ex_fwd2_sel;
  logic            ls_valid, ls_we, ls_is_load;
  logic [RA_W-1:0] ls_rd, wb_rd;
  logic            wb_valid, wb_we;
  logic            flush, halt;
`ifdef EX_PERF_CNT_EN
  logic [CNT_W-1:0] perf_ex_retired, perf_ld_stall;
`endif

  ysyx22041405_ex_sched dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .id_ebreak    (id_ebreak),
    .ex_valid     (ex_valid),
    .ex_out_valid (ex_out_valid),
    .ls_ready     (ls_ready),
    .ex_fwd1_sel  (ex_fwd1_sel),
    .ex_fwd2_sel  (ex_fwd2_sel),
    .ls_valid     (ls_valid),
    .ls_rd        (ls_rd),
    .ls_we        (ls_we),
    .ls_is_load   (ls_is_load),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .flush        (flush),
    .halt         (halt)
`ifdef EX_PERF_CNT_EN
    ,
    .perf_ex_retired (perf_ex_retired),
    .perf_ld_stall   (perf_ld_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] fwd1;
    logic [1:0] fwd2;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    e.fwd1 = f1;
    e.fwd2 = f2;
    sb_q.push_back(e);
  endtask

  task automatic drive_op(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic u1, input logic u2, input logic [RA_W-1:0] rd,
                          input logic we, input logic ld, input logic eb);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = rd;
    id_we       = we;
    id_is_load  = ld;
    id_ebreak   = eb;
  endtask

  // Scoreboard monitor: every instruction leaving EX must match the oldest
  // pending expectation.
  always @(negedge clk) begin
    if (!rst && ex_out_valid && ls_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_go: observed go with empty queue, expected none");
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_fwd1", 32'(ex_fwd1_sel), 32'(e.fwd1));
        check("sb_fwd2", 32'(ex_fwd2_sel), 32'(e.fwd2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_we = 1'b0;
    id_is_load = 1'b0; id_ebreak = 1'b0;
    ls_ready = 1'b1; ls_valid = 1'b0; ls_rd = '0; ls_we = 1'b0; ls_is_load = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_we = 1'b0; flush = 1'b0;

    // ---- reset state
    sample();
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_fwd1", 32'(ex_fwd1_sel), 0);
    check("rst_fwd2", 32'(ex_fwd2_sel), 0);
    check("rst_out_valid", 32'(ex_out_valid), 0);
    check("rst_id_ready", 32'(id_ready), 1);
    tick();
    rst = 1'b0;

    // ---- streaming: 4 independent ops, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive_op(RA_W'(i + 1), '0, 1'b1, 1'b0, RA_W'(i + 16), 1'b1, 1'b0, 1'b0);
      push(2'b00, 2'b00);
      sample();
      check("stream_id_ready", 32'(id_ready), 1);
      if (i > 0) check("stream_go", 32'(ex_out_valid), 1);
      tick();
    end
    id_valid = 1'b0;
    sample();
    check("stream_go_last", 32'(ex_out_valid), 1);
    tick();
    sample();
    check("stream_empty", 32'(ex_valid), 0);
    tick();

    // ---- forwarding priority + 3 cycles of backpressure
    ls_ready = 1'b0;
    drive_op(5'd5, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    sample();
    check("fwd_accept", 32'(id_ready), 1);
    tick();
    // Z waits in ID during backpressure: rs1=2, rs2=6
    drive_op(5'd2, 5'd6, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    ls_valid = 1'b1; ls_rd = 5'd5; ls_we = 1'b1; ls_is_load = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_we = 1'b1;
    sample();
    check("fwd_ls_wins", 32'(ex_fwd1_sel), 32'h1);
    check("bp1_id_ready", 32'(id_ready), 0);
    tick();
    ls_rd = 5'd6;
    sample();
    check("fwd_wb", 32'(ex_fwd1_sel), 32'h2);
    check("bp2_id_ready", 32'(id_ready), 0);
    check("bp2_ex_valid", 32'(ex_valid), 1);
    tick();
    sample();
    check("bp3_id_ready", 32'(id_ready), 0);
    check("bp3_ex_valid", 32'(ex_valid), 1);
    tick();
    push(2'b10, 2'b00);
    ls_ready = 1'b1;
    sample();
    check("bp_release_id_ready", 32'(id_ready), 1);
    tick();
    id_valid = 1'b0;
    push(2'b00, 2'b01);  // Z: rs2=6 hits non-load LS
    sample();
    check("z_out_valid", 32'(ex_out_valid), 1);
    tick();
    ls_valid = 1'b0; wb_valid = 1'b0;

    // ---- rs1 = x0 never forwards
    drive_op(5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    ls_valid = 1'b1; ls_rd = 5'd0; ls_we = 1'b1;
    push(2'b00, 2'b00);
    sample();
    tick();
    id_valid = 1'b0;
    sample();
    check("x0_fwd1", 32'(ex_fwd1_sel), 0);
    tick();
    ls_valid = 1'b0;

    // ---- asynchronous reset mid-run clears the slot at once
    ls_ready = 1'b0;
    drive_op(5'd5, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
    sample();
    tick();
    id_valid = 1'b0;
    ls_valid = 1'b1; ls_rd = 5'd5; ls_we = 1'b1;
    sample();
    check("pre_rst_fwd1", 32'(ex_fwd1_sel), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ex_valid", 32'(ex_valid), 0);
    check("async_rst_fwd1", 32'(ex_fwd1_sel), 0);
    tick();
    rst = 1'b0;
    ls_valid = 1'b0; ls_ready = 1'b1;

    // ---- flush beats id_valid on an empty slot
    drive_op(5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    sample();
    check("flush_id_ready", 32'(id_ready), 0);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    sample();
    check("flush_no_capture", 32'(ex_valid), 0);
    tick();
    // flush kills an occupied slot
    ls_ready = 1'b0;
    drive_op(5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    sample();
    tick();
    id_valid = 1'b0; flush = 1'b1;
    sample();
    check("flush_pre_ex_valid", 32'(ex_valid), 1);
    tick();
    flush = 1'b0; ls_ready = 1'b1;
    sample();
    check("flush_kill", 32'(ex_valid), 0);
    tick();

    // ---- ebreak, killed by flush while draining
    ls_ready = 1'b0;
    drive_op('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    sample();
    check("ebk1_accept", 32'(id_ready), 1);
    tick();
    id_valid = 1'b0; flush = 1'b1;
    sample();
    check("drain_id_ready", 32'(id_ready), 0);
    tick();
    flush = 1'b0; ls_ready = 1'b1;
    sample();
    check("drain_flush_run", 32'(id_ready), 1);
    check("drain_flush_halt", 32'(halt), 0);
    tick();

    // ---- ebreak retires and halts
    drive_op('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    push(2'b00, 2'b00);
    sample();
    tick();
    drive_op(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    sample();
    check("ebk2_id_ready", 32'(id_ready), 0);
    check("ebk2_go", 32'(ex_out_valid), 1);
    check("ebk2_halt_pre", 32'(halt), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      sample();
      check("halt_sticky", 32'(halt), 1);
      check("halt_id_ready", 32'(id_ready), 0);
      tick();
    end
    id_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_clears_halt", 32'(halt), 0);
    tick();
    rst = 1'b0;

    // ---- load-use: exactly one bubble, then WB forward (3 retires, 1 stall)
    drive_op(5'd0, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    sample();
    check("lu_accept", 32'(id_ready), 1);
    tick();
    drive_op(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    ls_valid = 1'b1; ls_rd = 5'd3; ls_we = 1'b1; ls_is_load = 1'b1;
    sample();
    check("lu_out_valid", 32'(ex_out_valid), 0);
    check("lu_id_ready", 32'(id_ready), 0);
    tick();
    ls_valid = 1'b0; ls_is_load = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_we = 1'b1;
    push(2'b00, 2'b10);
    sample();
    check("lu_fwd2_wb", 32'(ex_fwd2_sel), 32'h2);
    check("lu_resume", 32'(ex_out_valid), 1);
    tick();
    push(2'b00, 2'b00);
    wb_valid = 1'b0;
    drive_op(5'd11, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    sample();
    check("lu_b_go_c_accept", 32'(id_ready), 1);
    tick();
    push(2'b00, 2'b00);
    id_valid = 1'b0;
    sample();
    tick();
    sample();
    check("lu_empty", 32'(ex_valid), 0);
`ifdef EX_PERF_CNT_EN
    check("perf_retired", perf_ex_retired, 3);
    check("perf_ld_stall", perf_ld_stall, 1);
`endif
    tick();

    // ---- ebreak ex_go coincides with flush in DRAIN: retirement wins
    ls_ready = 1'b0;
    drive_op('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    sample();
    tick();
    id_valid = 1'b0; id_ebreak = 1'b0;
    push(2'b00, 2'b00);
    flush = 1'b1; ls_ready = 1'b1;
    sample();
    check("go_flush_out_valid", 32'(ex_out_valid), 1);
    tick();
    flush = 1'b0;
    sample();
    check("go_flush_halt", 32'(halt), 1);
    check("go_flush_ex_valid", 32'(ex_valid), 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
